// File: rtl/tt_um_subtractor_serial.sv
// Digit-serial subtractor: a - b over WIDTH bits, DIGIT bits per clock, with
// wrap / unsigned-saturating / signed-saturating result modes and raw-result flags.
module tt_um_subtractor_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;

    logic             accept, step_en, last;
    logic [DIGIT:0]   step;
    logic [WIDTH-1:0] raw, sat;
    logic             ovf_n;

    assign accept  = in_valid & in_ready;
    assign step_en = (state_q == RUN);
    assign last    = (cnt_q == CW'(NSTEP - 1));
    assign step    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, bw_q};

    // raw is the result after the current digit lands at the MSB; the
    // accumulator only keeps the WIDTH-DIGIT bits that survive the next shift
    if (DIGIT < WIDTH) begin : g_acc
        logic [WIDTH-DIGIT-1:0] res_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)          res_q <= '0;
            else if (accept)  res_q <= '0;
            else if (step_en) res_q <= raw[WIDTH-1:DIGIT];
        end
        assign raw = {step[DIGIT-1:0], res_q};
    end else begin : g_noacc
        assign raw = step[DIGIT-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE) & ~rst;
        out_valid = (state_q == DONE);
        diff      = diff_q;
        borrow    = borrow_q;
        ovf       = ovf_q;
        zero      = zero_q;
    end

    always_comb begin
        ovf_n = (a_msb_q != b_msb_q) & (raw[WIDTH-1] != a_msb_q);
        case (mode_q)
            2'b01:   sat = step[DIGIT] ? '0 : raw;
            2'b10:   sat = ovf_n ? (a_msb_q ? SMIN : SMAX) : raw;
            default: sat = raw;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            mode_d  = mode;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
            bw_d    = 1'b0;
            cnt_d   = '0;
        end else if (step_en) begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            bw_d  = step[DIGIT];
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                diff_d   = sat;
                borrow_d = step[DIGIT];
                ovf_d    = ovf_n;
                zero_d   = (sat == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_tt_um_subtractor_serial.sv
// Directed bench for tt_um_subtractor_serial: DIGIT=4 default instance plus
// DIGIT=1 and DIGIT=16 instances checked against a behavioural reference.
module tb_tt_um_subtractor_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_r = '0, b_r = '0;
    logic [1:0]  mode_r = '0;
    logic        in_valid_r [3];
    logic        out_ready_r[3];
    logic        in_ready_w [3];
    logic        out_valid_w[3];
    logic [15:0] diff_w     [3];
    logic        borrow_w   [3];
    logic        ovf_w      [3];
    logic        zero_w     [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tt_um_subtractor_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[0]), .in_ready(in_ready_w[0]),
        .a(a_r), .b(b_r), .mode(mode_r), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_r[0]), .diff(diff_w[0]), .borrow(borrow_w[0]),
        .ovf(ovf_w[0]), .zero(zero_w[0]));

    tt_um_subtractor_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[1]), .in_ready(in_ready_w[1]),
        .a(a_r), .b(b_r), .mode(mode_r), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_r[1]), .diff(diff_w[1]), .borrow(borrow_w[1]),
        .ovf(ovf_w[1]), .zero(zero_w[1]));

    tt_um_subtractor_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_r[2]), .in_ready(in_ready_w[2]),
        .a(a_r), .b(b_r), .mode(mode_r), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_r[2]), .diff(diff_w[2]), .borrow(borrow_w[2]),
        .ovf(ovf_w[2]), .zero(zero_w[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {diff, borrow, ovf, zero} from plain integer arithmetic
    function automatic logic [18:0] ref_model(input logic [15:0] av, input logic [15:0] bv,
                                              input logic [1:0] mv);
        logic [15:0] r, d;
        logic        bo, ov;
        r  = av - bv;
        bo = (av < bv);
        ov = (av[15] != bv[15]) && (r[15] != av[15]);
        d  = r;
        if (mv == 2'b01 && bo) d = 16'h0000;
        if (mv == 2'b10 && ov) d = av[15] ? 16'h8000 : 16'h7FFF;
        return {d, bo, ov, (d == 16'h0000)};
    endfunction

    task automatic start_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                            input logic [1:0] mv);
        int n = 0;
        @(negedge clk);
        while (!in_ready_w[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready_w[k]), 32'd1);
        a_r = av;
        b_r = bv;
        mode_r = mv;
        in_valid_r[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_r[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int exp_lat);
        int lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid_w[k] && lat < 100);
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input int k);
        @(negedge clk);
        out_ready_r[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_r[k] = 1'b0;
        check("post_hs.out_valid", 32'(out_valid_w[k]), 32'd0);
        check("post_hs.in_ready", 32'(in_ready_w[k]), 32'd1);
    endtask

    task automatic check_res(input string tag, input int k, input logic [15:0] ed,
                             input logic eb, input logic eo, input logic ez);
        check({tag, ".diff"},   32'(diff_w[k]),   32'(ed));
        check({tag, ".borrow"}, 32'(borrow_w[k]), 32'(eb));
        check({tag, ".ovf"},    32'(ovf_w[k]),    32'(eo));
        check({tag, ".zero"},   32'(zero_w[k]),   32'(ez));
    endtask

    task automatic op(input string tag, input int k, input logic [15:0] av, input logic [15:0] bv,
                      input logic [1:0] mv, input int lat, input logic [15:0] ed,
                      input logic eb, input logic eo, input logic ez);
        start_op(k, av, bv, mv);
        wait_done(k, lat);
        check_res(tag, k, ed, eb, eo, ez);
        finish_op(k);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rm;
        logic [18:0] exp_v;
        int          lat_of[3];
        lat_of[0] = 4;
        lat_of[1] = 16;
        lat_of[2] = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid_r[k]  = 1'b0;
            out_ready_r[k] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready_w[0]), 32'd0);
        check("rst.out_valid", 32'(out_valid_w[0]), 32'd0);
        check_res("rst", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle.in_ready", 32'(in_ready_w[0]), 32'd1);

        // Basic wrap, borrow and unsigned saturation
        op("t1", 0, 16'h1234, 16'h0034, 2'b00, 4, 16'h1200, 1'b0, 1'b0, 1'b0);
        op("t2w", 0, 16'h0005, 16'h0007, 2'b00, 4, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        op("t2u", 0, 16'h0005, 16'h0007, 2'b01, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
        op("t2m3", 0, 16'h0005, 16'h0007, 2'b11, 4, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        op("t2s", 0, 16'h0005, 16'h0007, 2'b10, 4, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // Signed saturation
        op("t3z", 0, 16'h0003, 16'h0003, 2'b10, 4, 16'h0000, 1'b0, 1'b0, 1'b1);
        op("t3n", 0, 16'h8000, 16'h0001, 2'b10, 4, 16'h8000, 1'b0, 1'b1, 1'b0);
        op("t3p", 0, 16'h7FFF, 16'hFFFF, 2'b10, 4, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        op("t3w", 0, 16'h8000, 16'h0001, 2'b00, 4, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        // Output back-pressure: result held, new operands ignored
        start_op(0, 16'h0005, 16'h0007, 2'b00);
        wait_done(0, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_r = 16'hAAAA;
            b_r = 16'h1111;
            mode_r = 2'b01;
            in_valid_r[0] = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("hold.diff", 32'(diff_w[0]), 32'h0000FFFE);
            check("hold.out_valid", 32'(out_valid_w[0]), 32'd1);
            check("hold.in_ready", 32'(in_ready_w[0]), 32'd0);
        end
        @(negedge clk);
        in_valid_r[0] = 1'b0;
        finish_op(0);
        check_res("hold_after", 0, 16'hFFFE, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of RUN
        start_op(0, 16'h1234, 16'h0001, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst.out_valid", 32'(out_valid_w[0]), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready_w[0]), 32'd0);
        check_res("mid_rst", 0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel.in_ready", 32'(in_ready_w[0]), 32'd1);
        op("t5", 0, 16'h0100, 16'h0001, 2'b00, 4, 16'h00FF, 1'b0, 1'b0, 1'b0);

        // DIGIT=1 and DIGIT=16 builds
        op("d1", 1, 16'h8000, 16'h0001, 2'b10, 16, 16'h8000, 1'b0, 1'b1, 1'b0);
        op("d16", 2, 16'h1234, 16'h0034, 2'b00, 1, 16'h1200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                ra = 16'($urandom);
                rb = (i == 0) ? ra : 16'($urandom);
                rm = 2'($urandom_range(0, 3));
                exp_v = ref_model(ra, rb, rm);
                op("rnd", k, ra, rb, rm, lat_of[k], exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
